// File: rtl/ecc_22_wr_enc_if.sv
// Stream bundle for the 22-bit SECDED write encoder.
//   s_valid/s_ready/s_data    : input beat handshake and payload
//   m_valid/m_ready           : codeword handshake toward the RAM write port
//   m_data/m_parity           : codeword data and check fields
// slave modport is the encoder's view; master modport is the driver/sink side.
interface ecc_22_wr_enc_if;
    localparam int unsigned DATA_WIDTH   = 22;
    localparam int unsigned PARITY_WIDTH = 6;

    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [PARITY_WIDTH-1:0] m_parity;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_parity
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_parity
    );
endinterface

// File: rtl/ecc_22_wr_enc.sv
// Registered SECDED write-side encoder for the 22-bit ECC FIFO RAM path, with
// a one-shot single/double bit error injector for exercising the decoder.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : input beat handshake and codeword output (slave modport)
//   inj_en       : one-cycle pulse that arms an injection
//   inj_mode     : 00 none, 01 single flip, 10 double flip, 11 none
//   inj_pos0/1   : codeword bit indices to flip (0..21 data, 22..27 parity)
//   inj_armed    : an injection is waiting for the next accepted beat
//   inj_cnt      : saturating count of beats that carried injected flips
module ecc_22_wr_enc #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ecc_22_wr_enc_if.slave   bus,
    input  logic             inj_en,
    input  logic [1:0]       inj_mode,
    input  logic [4:0]       inj_pos0,
    input  logic [4:0]       inj_pos1,
    output logic             inj_armed,
    output logic [CNT_W-1:0] inj_cnt
);
    localparam int unsigned DATA_WIDTH   = 22;
    localparam int unsigned PARITY_WIDTH = 6;
    localparam int unsigned CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH;

    logic                    m_valid_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic [PARITY_WIDTH-1:0] m_parity_q;
    logic                    armed_q;
    logic                    double_q;
    logic [4:0]              pos0_q;
    logic [4:0]              pos1_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    s_ready_c;
    logic                    accept_c;
    logic [PARITY_WIDTH-1:0] parity_c;
    logic [31:0]             flip_c;
    logic [CW_WIDTH-1:0]     cw_mask_c;

    assign s_ready_c    = !m_valid_q || bus.m_ready;
    assign accept_c     = bus.s_valid && s_ready_c;

    assign bus.s_ready  = s_ready_c;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_parity = m_parity_q;
    assign inj_armed    = armed_q;
    assign inj_cnt      = cnt_q;

    // Check bits from the clean payload
    always_comb begin
        logic [DATA_WIDTH-1:0] d;
        d = bus.s_data;
        parity_c    = '0;
        parity_c[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11]
                    ^ d[13] ^ d[15] ^ d[17] ^ d[19] ^ d[21];
        parity_c[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12]
                    ^ d[13] ^ d[16] ^ d[17] ^ d[20] ^ d[21];
        parity_c[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14]
                    ^ d[15] ^ d[16] ^ d[17];
        parity_c[3] = ^{d[21:18], d[10:4]};
        parity_c[4] = ^d[21:11];
        parity_c[5] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11]
                    ^ d[12] ^ d[14] ^ d[17] ^ d[18] ^ d[21];
    end

    // Flip mask; indices 28..31 fall outside the codeword and flip nothing,
    // and pos0==pos1 in double mode collapses to one flip via the OR.
    always_comb begin
        flip_c = '0;
        if (armed_q) begin
            flip_c = 32'(1) << pos0_q;
            if (double_q) begin
                flip_c = flip_c | (32'(1) << pos1_q);
            end
        end
        cw_mask_c = flip_c[CW_WIDTH-1:0];
    end

    // Output register: loads on input handshake, drains on m_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_parity_q <= '0;
        end else if (accept_c) begin
            m_valid_q  <= 1'b1;
            m_data_q   <= bus.s_data ^ cw_mask_c[DATA_WIDTH-1:0];
            m_parity_q <= parity_c ^ cw_mask_c[CW_WIDTH-1:DATA_WIDTH];
        end else if (bus.m_ready) begin
            m_valid_q  <= 1'b0;
        end
    end

    // Injection arming, consumption and event count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q  <= 1'b0;
            double_q <= 1'b0;
            pos0_q   <= '0;
            pos1_q   <= '0;
            cnt_q    <= '0;
        end else if (armed_q) begin
            if (accept_c) begin
                armed_q <= 1'b0;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end else if (inj_en && (inj_mode == 2'b01 || inj_mode == 2'b10)) begin
            armed_q  <= 1'b1;
            double_q <= inj_mode[1];
            pos0_q   <= inj_pos0;
            pos1_q   <= inj_pos1;
        end
    end
endmodule
